// File: rtl/csr_pkg.sv
// Shared definitions for the machine-mode CSR unit: op encoding, CSR map,
// status/enable/pending bit positions and trap cause codes.
package csr_pkg;

    typedef enum logic [2:0] {
        OP_NONE  = 3'd0,
        OP_CSRRW = 3'd1,
        OP_CSRRS = 3'd2,
        OP_CSRRC = 3'd3,
        OP_ECALL = 3'd4,
        OP_MRET  = 3'd5
    } csr_op_e;

    localparam logic [11:0] CSR_MSTATUS   = 12'h300;
    localparam logic [11:0] CSR_MISA      = 12'h301;
    localparam logic [11:0] CSR_MIE       = 12'h304;
    localparam logic [11:0] CSR_MTVEC     = 12'h305;
    localparam logic [11:0] CSR_MSCRATCH  = 12'h340;
    localparam logic [11:0] CSR_MEPC      = 12'h341;
    localparam logic [11:0] CSR_MCAUSE    = 12'h342;
    localparam logic [11:0] CSR_MIP       = 12'h344;
    localparam logic [11:0] CSR_MCYCLE    = 12'hB00;
    localparam logic [11:0] CSR_MCYCLEH   = 12'hB80;
    localparam logic [11:0] CSR_MVENDORID = 12'hF11;
    localparam logic [11:0] CSR_MARCHID   = 12'hF12;
    localparam logic [11:0] CSR_MHARTID   = 12'hF14;

    localparam int MSTATUS_MIE    = 3;
    localparam int MSTATUS_MPIE   = 7;
    localparam int MSTATUS_MPP_LO = 11;
    localparam int MSTATUS_MPP_HI = 12;
    localparam int MIE_MTIE       = 7;
    localparam int MIP_MTIP       = 7;

    // Interrupt causes additionally set bit XLEN-1 of mcause.
    localparam int CAUSE_ECALL_M = 11;
    localparam int CAUSE_MTI     = 7;

    function automatic logic is_csr_op(input csr_op_e op);
        return (op == OP_CSRRW) || (op == OP_CSRRS) || (op == OP_CSRRC);
    endfunction

endpackage

// File: rtl/csr_if.sv
// Decode-stage / PC-mux side bus of the CSR unit. The core drives i_* and
// consumes o_*; the CSR unit is the slave.
interface csr_if #(
    parameter int XLEN = 32
);
    logic            i_valid;
    logic [2:0]      i_op;
    logic [11:0]     i_csr;
    logic [XLEN-1:0] i_pc;
    logic [XLEN-1:0] i_wdata;
    logic [XLEN-1:0] i_mcause;
    logic            i_irq;
    logic [XLEN-1:0] o_rdata;
    logic            o_illegal;
    logic            o_redirect;
    logic [XLEN-1:0] o_upc;
    logic            o_irq_take;

    modport master (
        output i_valid, i_op, i_csr, i_pc, i_wdata, i_mcause, i_irq,
        input  o_rdata, o_illegal, o_redirect, o_upc, o_irq_take
    );

    modport slave (
        input  i_valid, i_op, i_csr, i_pc, i_wdata, i_mcause, i_irq,
        output o_rdata, o_illegal, o_redirect, o_upc, o_irq_take
    );
endinterface

// File: rtl/csr_mcycle.sv
// Free-running 64-bit cycle counter. A write to either half replaces only
// that half of the incremented value, so the carry still reaches the other.
module csr_mcycle (
    input  logic        i_clock,
    input  logic        i_reset_n,
    input  logic        i_wr_lo,
    input  logic        i_wr_hi,
    input  logic [31:0] i_wdata_lo,
    input  logic [31:0] i_wdata_hi,
    output logic [63:0] o_count
);

    logic [63:0] count_q;
    logic [63:0] count_d;

    // NOTE: count_d is assigned unconditionally first, so no path leaves it
    // unassigned and no latch is inferred.
    always_comb begin
        count_d = count_q + 64'd1;
        if (i_wr_lo) count_d[31:0]  = i_wdata_lo;
        if (i_wr_hi) count_d[63:32] = i_wdata_hi;
    end

    // NOTE: state registers use non-blocking assignments so every flop
    // samples its d-input from before the edge.
    always_ff @(posedge i_clock or negedge i_reset_n) begin
        if (!i_reset_n) count_q <= '0;
        else            count_q <= count_d;
    end

    assign o_count = count_q;

endmodule

// File: rtl/csr_unit.sv
// Machine-mode CSR file and trap sequencer: Zicsr ops, ECALL/MRET status
// stacking, machine-timer interrupt entry and the 64-bit mcycle counter.
module csr_unit
    import csr_pkg::*;
#(
    parameter int              XLEN        = 32,
    parameter logic [XLEN-1:0] MTVEC_RESET = XLEN'(64'h8000_0000),
    parameter logic [XLEN-1:0] MHARTID     = '0,
    parameter logic [XLEN-1:0] MISA_VAL    = XLEN'(64'h4000_0100)
) (
    input  logic  i_clock,
    input  logic  i_reset_n,
    csr_if.slave  bus
);

    localparam logic [XLEN-1:0] IRQ_CAUSE  = (XLEN'(1) << (XLEN - 1)) | XLEN'(CAUSE_MTI);
    localparam logic [XLEN-1:0] ALIGN_MASK = ~XLEN'(3);

    csr_op_e         op;
    logic            mst_mie_q, mst_mie_d;
    logic            mst_mpie_q, mst_mpie_d;
    logic            mie_mtie_q, mie_mtie_d;
    logic [XLEN-1:0] mtvec_q, mtvec_d;
    logic [XLEN-1:0] mscratch_q, mscratch_d;
    logic [XLEN-1:0] mepc_q, mepc_d;
    logic [XLEN-1:0] mcause_q, mcause_d;
    logic [63:0]     mcycle;

    logic            hit, read_only;
    logic            take_irq, csr_act, wr_req, illegal, csr_we;
    logic            do_ecall, do_mret;
    logic [XLEN-1:0] old_val, new_val;
    logic [XLEN-1:0] mtvec_rd, mepc_rd;
    logic            mc_wr_lo, mc_wr_hi;
    logic [31:0]     mc_wdata_lo, mc_wdata_hi;

    assign op       = csr_op_e'(bus.i_op);
    assign mtvec_rd = mtvec_q & ALIGN_MASK;
    assign mepc_rd  = mepc_q & ALIGN_MASK;

    // Read mux: current value of the addressed CSR plus its access class.
    always_comb begin
        hit       = 1'b1;
        read_only = 1'b0;
        old_val   = '0;
        case (bus.i_csr)
            CSR_MSTATUS: begin
                old_val[MSTATUS_MPP_HI:MSTATUS_MPP_LO] = 2'b11;
                old_val[MSTATUS_MPIE]                  = mst_mpie_q;
                old_val[MSTATUS_MIE]                   = mst_mie_q;
            end
            CSR_MISA: begin
                old_val   = MISA_VAL;
                read_only = 1'b1;
            end
            CSR_MIE:      old_val[MIE_MTIE] = mie_mtie_q;
            CSR_MTVEC:    old_val = mtvec_rd;
            CSR_MSCRATCH: old_val = mscratch_q;
            CSR_MEPC:     old_val = mepc_rd;
            CSR_MCAUSE:   old_val = mcause_q;
            CSR_MIP: begin
                old_val[MIP_MTIP] = bus.i_irq;
                read_only         = 1'b1;
            end
            CSR_MCYCLE:   old_val = XLEN'(mcycle);
            CSR_MCYCLEH: begin
                if (XLEN == 32) old_val = XLEN'(mcycle[63:32]);
                else            hit     = 1'b0;
            end
            CSR_MVENDORID, CSR_MARCHID: read_only = 1'b1;
            CSR_MHARTID: begin
                old_val   = MHARTID;
                read_only = 1'b1;
            end
            default: hit = 1'b0;
        endcase
    end

    // Op decode. A taken interrupt squashes whatever op is in flight.
    always_comb begin
        take_irq = bus.i_valid & mst_mie_q & mie_mtie_q & bus.i_irq;
        csr_act  = bus.i_valid & ~take_irq & is_csr_op(op);
        do_ecall = bus.i_valid & ~take_irq & (op == OP_ECALL);
        do_mret  = bus.i_valid & ~take_irq & (op == OP_MRET);
        wr_req   = (op == OP_CSRRW) | (|bus.i_wdata);
        illegal  = csr_act & (~hit | (read_only & wr_req));
        csr_we   = csr_act & hit & ~read_only & wr_req;
        case (op)
            OP_CSRRW: new_val = bus.i_wdata;
            OP_CSRRS: new_val = old_val | bus.i_wdata;
            OP_CSRRC: new_val = old_val & ~bus.i_wdata;
            default:  new_val = old_val;
        endcase
    end

    assign bus.o_rdata    = illegal ? '0 : old_val;
    assign bus.o_illegal  = i_reset_n & illegal;
    assign bus.o_irq_take = i_reset_n & take_irq;
    assign bus.o_redirect = i_reset_n & (take_irq | do_ecall | do_mret);
    assign bus.o_upc      = !i_reset_n ? '0 : (do_mret ? mepc_rd : mtvec_rd);

    always_comb begin
        mst_mie_d  = mst_mie_q;
        mst_mpie_d = mst_mpie_q;
        mie_mtie_d = mie_mtie_q;
        mtvec_d    = mtvec_q;
        mscratch_d = mscratch_q;
        mepc_d     = mepc_q;
        mcause_d   = mcause_q;
        if (take_irq || do_ecall) begin
            mepc_d     = bus.i_pc;
            mcause_d   = take_irq ? IRQ_CAUSE : bus.i_mcause;
            mst_mpie_d = mst_mie_q;
            mst_mie_d  = 1'b0;
        end else if (do_mret) begin
            mst_mie_d  = mst_mpie_q;
            mst_mpie_d = 1'b1;
        end else if (csr_we) begin
            case (bus.i_csr)
                CSR_MSTATUS: begin
                    mst_mie_d  = new_val[MSTATUS_MIE];
                    mst_mpie_d = new_val[MSTATUS_MPIE];
                end
                CSR_MIE:      mie_mtie_d = new_val[MIE_MTIE];
                CSR_MTVEC:    mtvec_d    = new_val;
                CSR_MSCRATCH: mscratch_d = new_val;
                CSR_MEPC:     mepc_d     = new_val;
                CSR_MCAUSE:   mcause_d   = new_val;
                default: ;
            endcase
        end
    end

    if (XLEN == 64) begin : g_mcycle_x64
        assign mc_wr_lo    = csr_we & (bus.i_csr == CSR_MCYCLE);
        assign mc_wr_hi    = mc_wr_lo;
        assign mc_wdata_lo = new_val[31:0];
        assign mc_wdata_hi = new_val[63:32];
    end else begin : g_mcycle_x32
        assign mc_wr_lo    = csr_we & (bus.i_csr == CSR_MCYCLE);
        assign mc_wr_hi    = csr_we & (bus.i_csr == CSR_MCYCLEH);
        assign mc_wdata_lo = new_val[31:0];
        assign mc_wdata_hi = new_val[31:0];
    end

    csr_mcycle u_mcycle (
        .i_clock    (i_clock),
        .i_reset_n  (i_reset_n),
        .i_wr_lo    (mc_wr_lo),
        .i_wr_hi    (mc_wr_hi),
        .i_wdata_lo (mc_wdata_lo),
        .i_wdata_hi (mc_wdata_hi),
        .o_count    (mcycle)
    );

    always_ff @(posedge i_clock or negedge i_reset_n) begin
        if (!i_reset_n) begin
            mst_mie_q  <= 1'b0;
            mst_mpie_q <= 1'b0;
            mie_mtie_q <= 1'b0;
            mtvec_q    <= MTVEC_RESET;
            mscratch_q <= '0;
            mepc_q     <= '0;
            mcause_q   <= '0;
        end else begin
            mst_mie_q  <= mst_mie_d;
            mst_mpie_q <= mst_mpie_d;
            mie_mtie_q <= mie_mtie_d;
            mtvec_q    <= mtvec_d;
            mscratch_q <= mscratch_d;
            mepc_q     <= mepc_d;
            mcause_q   <= mcause_d;
        end
    end

endmodule
